// File: rtl/core_mem_stage_pkg.sv
// Shared types for the memory stage: FSM state, mem_type codes,
// the hold-register bundle and the memory-to-writeback bundle.
package core_mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  localparam logic [2:0] MT_B  = 3'd0;
  localparam logic [2:0] MT_H  = 3'd1;
  localparam logic [2:0] MT_W  = 3'd2;
  localparam logic [2:0] MT_BU = 3'd4;
  localparam logic [2:0] MT_HU = 3'd5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        reg_wen;
    logic [1:0]  reg_wsel;
    logic [31:0] alu_out;
    logic [31:0] alu_sum;
    logic [2:0]  mem_type;
    logic        mem_wen;
    logic [31:0] csr_value;
  } mem_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_wen;
    logic [1:0]  reg_wsel;
    logic [31:0] alu_out;
    logic [31:0] alu_sum;
    logic [2:0]  mem_type;
    logic [31:0] mem_rdata;
    logic [31:0] csr_value;
  } mem_wb_t;

endpackage

// File: rtl/core_mem_stage_if.sv
// Stage bundles: m_if (execute->memory, stage is master side,
// drives ready) and w_if (memory->writeback, stage drives valid).
interface m_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] imm;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        reg_wen;
  logic [1:0]  reg_wsel;
  logic [31:0] alu_out;
  logic [31:0] alu_sum;
  logic [2:0]  mem_type;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] csr_value;

  modport master (
    input  valid, pc, pc4, imm, rs2, rd,
    input  reg_wen, reg_wsel, alu_out, alu_sum,
    input  mem_type, mem_ren, mem_wen, csr_value,
    output ready
  );
endinterface

interface w_if;
  logic        valid;
  logic        ready;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] imm;
  logic [4:0]  rd;
  logic        reg_wen;
  logic [1:0]  reg_wsel;
  logic [31:0] alu_out;
  logic [31:0] alu_sum;
  logic [2:0]  mem_type;
  logic [31:0] mem_rdata;
  logic [31:0] csr_value;

  modport slave (
    output valid, pc, pc4, imm, rd,
    output reg_wen, reg_wsel, alu_out, alu_sum,
    output mem_type, mem_rdata, csr_value,
    input  ready
  );
endinterface

// File: rtl/core_store_align.sv
// Byte-enable and store-data lane steering.
// In: mem_type, addr[1:0], rs2. Out: be[3:0], wdata[31:0].
module core_store_align
  import core_mem_stage_pkg::*;
(
  input  logic [2:0]  mem_type,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  output logic [3:0]  be,
  output logic [31:0] wdata
);

  logic is_b;
  logic is_h;
  logic unused_mt;

  // Bit 2 only selects unsigned extension, done in writeback.
  assign unused_mt = mem_type[2];
  assign is_b = (mem_type[1:0] == MT_B[1:0]);
  assign is_h = (mem_type[1:0] == MT_H[1:0]);

  always_comb begin
    be    = 4'b1111;
    wdata = rs2;
    unique case (1'b1)
      is_b: begin
        be    = 4'b0001 << addr;
        wdata = {4{rs2[7:0]}};
      end
      is_h: begin
        // Misaligned halves silently align down.
        be    = 4'b0011 << {addr[1], 1'b0};
        wdata = {2{rs2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = rs2;
      end
    endcase
  end

endmodule

// File: rtl/core_mem_stage.sv
// Memory stage: one data-bus load/store per instruction, result in OR.
// Ports: clk, rst_n, m (upstream), w (downstream), dbus_* data bus.
module core_mem_stage
  import core_mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  m_if.master         m,
  w_if.slave          w,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  mem_state_t state;
  mem_state_t state_nxt;

  mem_op_t hold_q;
  mem_op_t m_op;
  mem_wb_t or_q;
  mem_wb_t alu_wb;
  mem_wb_t mem_wb;
  logic    or_vld;

  logic accept;
  logic is_mem;
  logic ld_alu;
  logic ld_mem;
  logic drain;

  logic [3:0]  al_be;
  logic [31:0] al_wdata;

  assign m.ready = (state == IDLE) && (!or_vld || w.ready);
  assign accept  = m.valid && m.ready;
  assign is_mem  = m.mem_ren || m.mem_wen;
  assign ld_alu  = accept && !is_mem;
  assign ld_mem  = (state == WAIT) && dbus_rvalid;
  assign drain   = or_vld && w.ready;

  always_comb begin
    m_op           = '0;
    m_op.pc        = m.pc;
    m_op.pc4       = m.pc4;
    m_op.imm       = m.imm;
    m_op.rs2       = m.rs2;
    m_op.rd        = m.rd;
    m_op.reg_wen   = m.reg_wen;
    m_op.reg_wsel  = m.reg_wsel;
    m_op.alu_out   = m.alu_out;
    m_op.alu_sum   = m.alu_sum;
    m_op.mem_type  = m.mem_type;
    m_op.mem_wen   = m.mem_wen;
    m_op.csr_value = m.csr_value;
  end

  always_comb begin
    alu_wb           = '0;
    alu_wb.pc        = m.pc;
    alu_wb.pc4       = m.pc4;
    alu_wb.imm       = m.imm;
    alu_wb.rd        = m.rd;
    alu_wb.reg_wen   = m.reg_wen;
    alu_wb.reg_wsel  = m.reg_wsel;
    alu_wb.alu_out   = m.alu_out;
    alu_wb.alu_sum   = m.alu_sum;
    alu_wb.mem_type  = m.mem_type;
    alu_wb.csr_value = m.csr_value;
  end

  // A set mem_wen wins over mem_ren, so stores return zero data.
  always_comb begin
    mem_wb           = '0;
    mem_wb.pc        = hold_q.pc;
    mem_wb.pc4       = hold_q.pc4;
    mem_wb.imm       = hold_q.imm;
    mem_wb.rd        = hold_q.rd;
    mem_wb.reg_wen   = hold_q.reg_wen;
    mem_wb.reg_wsel  = hold_q.reg_wsel;
    mem_wb.alu_out   = hold_q.alu_out;
    mem_wb.alu_sum   = hold_q.alu_sum;
    mem_wb.mem_type  = hold_q.mem_type;
    mem_wb.mem_rdata = hold_q.mem_wen ? 32'h0 : dbus_rdata;
    mem_wb.csr_value = hold_q.csr_value;
  end

  core_store_align u_align (
    .mem_type (hold_q.mem_type),
    .addr     (hold_q.alu_sum[1:0]),
    .rs2      (hold_q.rs2),
    .be       (al_be),
    .wdata    (al_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && is_mem) state_nxt = REQ;
      REQ:  if (dbus_gnt) state_nxt = WAIT;
      WAIT: if (dbus_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs are gated by REQ so they read zero when idle.
  always_comb begin
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = 32'h0;
    dbus_be    = 4'h0;
    dbus_wdata = 32'h0;
    if (state == REQ) begin
      dbus_req   = 1'b1;
      dbus_we    = hold_q.mem_wen;
      dbus_addr  = {hold_q.alu_sum[31:2], 2'b00};
      dbus_be    = al_be;
      dbus_wdata = hold_q.mem_wen ? al_wdata : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (accept && is_mem) begin
      hold_q <= m_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_vld <= 1'b0;
      or_q   <= '0;
    end else if (ld_alu) begin
      or_vld <= 1'b1;
      or_q   <= alu_wb;
    end else if (ld_mem) begin
      or_vld <= 1'b1;
      or_q   <= mem_wb;
    end else if (drain) begin
      or_vld <= 1'b0;
    end
  end

  assign w.valid     = or_vld;
  assign w.pc        = or_q.pc;
  assign w.pc4       = or_q.pc4;
  assign w.imm       = or_q.imm;
  assign w.rd        = or_q.rd;
  assign w.reg_wen   = or_q.reg_wen;
  assign w.reg_wsel  = or_q.reg_wsel;
  assign w.alu_out   = or_q.alu_out;
  assign w.alu_sum   = or_q.alu_sum;
  assign w.mem_type  = or_q.mem_type;
  assign w.mem_rdata = or_q.mem_rdata;
  assign w.csr_value = or_q.csr_value;

endmodule
